osnt_cutter_rr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares one packet cutter between
//  NUM_PORTS AXI4-Stream RX queues. Sits directly upstream of the cutter's

---
 rtl/osnt_cutter_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_osnt_cutter_rr_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osnt_cutter_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one packet cutter from NUM_PORTS
// AXI4-Stream queues; whole packets only, with per-port forwarded-packet counters.
module osnt_cutter_rr_arbiter #(
    parameter int NUM_PORTS          = 4,
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int CNT_WIDTH          = 32,
    localparam int DW = C_AXIS_DATA_WIDTH,
    localparam int KW = C_AXIS_DATA_WIDTH / 8,
    localparam int TU = C_AXIS_TUSER_WIDTH,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           axi_aclk,
    input  logic                           axi_resetn,
    input  logic [NUM_PORTS*DW-1:0]        s_axis_tdata,
    input  logic [NUM_PORTS*KW-1:0]        s_axis_tkeep,
    input  logic [NUM_PORTS*TU-1:0]        s_axis_tuser,
    input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]           s_axis_tlast,
    output logic [NUM_PORTS-1:0]           s_axis_tready,
    output logic [DW-1:0]                  m_axis_tdata,
    output logic [KW-1:0]                  m_axis_tkeep,
    output logic [TU-1:0]                  m_axis_tuser,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    input  logic                           arb_en,
    input  logic                           cnt_clr,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_cnt,
    output logic [PW-1:0]                  grant_port
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] grant;
    logic [PW-1:0] grant_nxt;
    logic [PW-1:0] last_grant;
    logic          arb_go;
    logic          beat_xfer;
    logic          pkt_done;

    // First requester after 'last', wrapping at NUM_PORTS; 'last' itself has lowest priority.
    function automatic logic [PW-1:0] rr_pick(input logic [PW-1:0] last,
                                              input logic [NUM_PORTS-1:0] req);
        logic [PW-1:0] pick;
        int            idx;
        pick = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_PORTS;
            if (req[idx]) begin
                pick = PW'(idx);
            end
        end
        return pick;
    endfunction

    // Clear wins over a same-cycle increment; increment wraps naturally.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic clr,
                                                      input logic inc);
        if (clr) begin
            return '0;
        end
        if (inc) begin
            return cur + CNT_WIDTH'(1);
        end
        return cur;
    endfunction

    always_comb begin
        arb_go    = arb_en && (|s_axis_tvalid);
        grant_nxt = rr_pick(last_grant, s_axis_tvalid);
        beat_xfer = (state == SEND) && s_axis_tvalid[grant] && m_axis_tready;
        pkt_done  = beat_xfer && s_axis_tlast[grant];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_go)   state_nxt = SEND;
            SEND:    if (pkt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= PW'(NUM_PORTS - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_go) begin
                grant <= grant_nxt;
            end
            if (pkt_done) begin
                last_grant <= grant;
            end
        end
    end

    // Zero-latency passthrough of the granted port; everything is quiet in IDLE.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state == SEND) begin
            m_axis_tdata         = s_axis_tdata[int'(grant)*DW +: DW];
            m_axis_tkeep         = s_axis_tkeep[int'(grant)*KW +: KW];
            m_axis_tuser         = s_axis_tuser[int'(grant)*TU +: TU];
            m_axis_tvalid        = s_axis_tvalid[grant];
            m_axis_tlast         = s_axis_tlast[grant];
            s_axis_tready[grant] = m_axis_tready;
        end
    end

    assign grant_port = grant;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;

        always_ff @(posedge axi_aclk or negedge axi_resetn) begin
            if (!axi_resetn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_next(cnt_q, cnt_clr, pkt_done && (grant == PW'(p)));
            end
        end

        assign pkt_cnt[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end

endmodule

// File: tb/tb_osnt_cutter_rr_arbiter.sv
// Randomised bench for osnt_cutter_rr_arbiter: per-port packet queues, a packet-level
// round-robin reference model and directed scenarios for ordering, stalls, wrap and reset.
module tb_osnt_cutter_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int TU = 8;
    localparam int CW = 4;
    localparam int PW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [TU-1:0] u;
        logic          l;
    } beat_t;

    logic              axi_aclk;
    logic              axi_resetn;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*KW-1:0]  s_axis_tkeep;
    logic [NP*TU-1:0]  s_axis_tuser;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [TU-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic              arb_en;
    logic              cnt_clr;
    logic [NP*CW-1:0]  pkt_cnt;
    logic [PW-1:0]     grant_port;

    osnt_cutter_rr_arbiter #(
        .NUM_PORTS         (NP),
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(TU),
        .CNT_WIDTH         (CW)
    ) dut (
        .axi_aclk     (axi_aclk),
        .axi_resetn   (axi_resetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .arb_en       (arb_en),
        .cnt_clr      (cnt_clr),
        .pkt_cnt      (pkt_cnt),
        .grant_port   (grant_port)
    );

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    int n_total = 0;
    int n_bad   = 0;

    beat_t         srcq [NP][$];
    logic [DW-1:0] exp_stream[$];
    logic [DW-1:0] obs[$];

    // Reference model: packet-level view of who owns the cutter.
    bit            m_busy;
    int            m_g;
    int            m_last;
    int            m_gp;
    logic [CW-1:0] m_cnt [NP];

    beat_t     cur [NP];
    logic [NP-1:0] v_d;
    logic      rdy_d;
    logic      clr_d;
    int        gap_pct     = 0;
    int        rdy_pct     = 100;
    bit        tog_mode    = 0;
    bit        clr_req     = 0;
    bit        clr_on_last = 0;
    int        cyc         = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_next(input int last, input logic [NP-1:0] v);
        for (int k = 1; k <= NP; k++) begin
            if (v[(last + k) % NP]) return (last + k) % NP;
        end
        return last;
    endfunction

    function automatic bit idle_all();
        bit e;
        e = !m_busy;
        for (int p = 0; p < NP; p++) if (srcq[p].size() != 0) e = 0;
        return e;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_g    = 0;
        m_last = NP - 1;
        m_gp   = 0;
        for (int p = 0; p < NP; p++) m_cnt[p] = '0;
    endtask

    task automatic add_pkt(input int p, input int n, input bit rec);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = $urandom;
            b.k = KW'($urandom);
            b.u = TU'($urandom);
            b.l = (i == n - 1);
            srcq[p].push_back(b);
            if (rec) exp_stream.push_back(b.d);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (srcq[p].size() > 0) begin
                cur[p] = srcq[p][0];
                v_d[p] = (int'($urandom_range(99)) >= gap_pct);
            end else begin
                cur[p] = '0;
                v_d[p] = 1'b0;
            end
            s_axis_tdata[p*DW +: DW] = cur[p].d;
            s_axis_tkeep[p*KW +: KW] = cur[p].k;
            s_axis_tuser[p*TU +: TU] = cur[p].u;
            s_axis_tlast[p]          = cur[p].l;
        end
        s_axis_tvalid = v_d;
        rdy_d = tog_mode ? cyc[0] : (int'($urandom_range(99)) < rdy_pct);
        clr_d = clr_req;
        clr_req = 0;
        if (clr_on_last && m_busy && v_d[m_g] && rdy_d && cur[m_g].l) clr_d = 1'b1;
        m_axis_tready = rdy_d;
        cnt_clr       = clr_d;
    endtask

    task automatic check_cycle();
        logic [63:0]   eb;
        logic [NP-1:0] er;
        eb = '0;
        er = '0;
        if (m_busy) begin
            eb = {18'b0, v_d[m_g], cur[m_g].l, cur[m_g].k, cur[m_g].u, cur[m_g].d};
            if (rdy_d) er[m_g] = 1'b1;
        end
        chk("bus", {18'b0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata}, eb);
        chk("rdy", 64'(s_axis_tready), 64'(er));
        chk("gnt", 64'(grant_port), 64'(m_gp));
        chk("cnt", 64'(pkt_cnt), 64'({m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}));
        if (m_axis_tvalid && rdy_d) obs.push_back(m_axis_tdata);
    endtask

    task automatic update();
        beat_t b;
        if (!axi_resetn) begin
            model_reset();
        end else begin
            if (m_busy) begin
                if (v_d[m_g] && rdy_d) begin
                    b = srcq[m_g].pop_front();
                    if (b.l) begin
                        m_cnt[m_g] = m_cnt[m_g] + 1'b1;
                        m_last = m_g;
                        m_busy = 0;
                    end
                end
            end else if (arb_en && (|v_d)) begin
                m_g    = rr_next(m_last, v_d);
                m_gp   = m_g;
                m_busy = 1;
            end
            if (clr_d) for (int p = 0; p < NP; p++) m_cnt[p] = '0;
        end
    endtask

    task automatic step();
        drive();
        #4;
        check_cycle();
        @(posedge axi_aclk);
        update();
        #1;
        cyc++;
    endtask

    task automatic drain(input int max, output int n);
        n = 0;
        while (!idle_all() && n < max) begin
            step();
            n++;
        end
        chk("tmo", 64'(idle_all()), 64'd1);
    endtask

    task automatic start_test();
        gap_pct  = 0;
        rdy_pct  = 100;
        tog_mode = 0;
        arb_en   = 1'b1;
        clr_req  = 1;
        step();
        obs.delete();
        exp_stream.delete();
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_n"}, 64'(obs.size()), 64'(exp_stream.size()));
        for (int i = 0; i < obs.size() && i < exp_stream.size(); i++) chk(tag, 64'(obs[i]), 64'(exp_stream[i]));
        obs.delete();
        exp_stream.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        axi_resetn    = 1'b0;
        arb_en        = 1'b0;
        cnt_clr       = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        model_reset();
        @(posedge axi_aclk);
        #1;
        repeat (3) step();
        chk("rst_v", 64'(m_axis_tvalid), 64'd0);
        chk("rst_cnt", 64'(pkt_cnt), 64'd0);
        axi_resetn = 1'b1;

        // 1: one 3-beat packet on every port, strict rotation with one bubble per packet
        start_test();
        for (int p = 0; p < NP; p++) add_pkt(p, 3, 1);
        drain(200, n);
        chk("t1cyc", 64'(n), 64'd16);
        chk("t1cnt", 64'(pkt_cnt), 64'h1111);
        cmp_stream("t1ord");

        // 2: port 2 alone, five back-to-back packets
        start_test();
        for (int i = 0; i < 5; i++) add_pkt(2, (i % 4) + 1, 1);
        drain(200, n);
        chk("t2cnt", 64'(pkt_cnt), 64'h0500);
        cmp_stream("t2ord");

        // 3: port 0 requests while port 1 is mid-packet under a toggling sink
        start_test();
        tog_mode = 1;
        add_pkt(1, 6, 1);
        for (int i = 0; i < 50 && srcq[1].size() > 4; i++) step();
        add_pkt(0, 3, 1);
        drain(200, n);
        tog_mode = 0;
        chk("t3cnt", 64'(pkt_cnt), 64'h0011);
        cmp_stream("t3ord");

        // 4: arb_en dropped on beat 2; packet completes, no new grant until re-enabled
        start_test();
        add_pkt(3, 4, 1);
        for (int i = 0; i < 50 && srcq[3].size() > 3; i++) step();
        arb_en = 1'b0;
        add_pkt(0, 2, 1);
        for (int i = 0; i < 50 && srcq[3].size() > 0; i++) step();
        repeat (4) step();
        chk("t4idle", 64'(m_axis_tvalid), 64'd0);
        chk("t4beats", 64'(obs.size()), 64'd4);
        arb_en = 1'b1;
        drain(200, n);
        chk("t4cnt", 64'(pkt_cnt), 64'h1001);
        cmp_stream("t4ord");

        // 5: counter wrap and clear-vs-increment priority
        start_test();
        for (int i = 0; i < 15; i++) add_pkt(0, 1, 0);
        drain(400, n);
        chk("t5full", 64'(pkt_cnt), 64'h000F);
        add_pkt(0, 1, 0);
        drain(50, n);
        chk("t5wrap", 64'(pkt_cnt), 64'h0000);
        add_pkt(3, 1, 0);
        drain(50, n);
        chk("t5one", 64'(pkt_cnt), 64'h1000);
        clr_on_last = 1;
        add_pkt(3, 1, 0);
        drain(50, n);
        clr_on_last = 0;
        chk("t5clr", 64'(pkt_cnt), 64'h0000);

        // 6: reset on beat 2 of a packet; rotation restarts at port 0
        start_test();
        add_pkt(1, 2, 0);
        drain(50, n);
        add_pkt(2, 4, 0);
        for (int i = 0; i < 50 && srcq[2].size() > 3; i++) step();
        drive();
        #2;
        axi_resetn = 1'b0;
        #1;
        chk("t6v", 64'(m_axis_tvalid), 64'd0);
        chk("t6r", 64'(s_axis_tready), 64'd0);
        for (int p = 0; p < NP; p++) srcq[p].delete();
        model_reset();
        @(posedge axi_aclk);
        #1;
        step();
        step();
        axi_resetn = 1'b1;
        obs.delete();
        exp_stream.delete();
        for (int p = 0; p < NP; p++) add_pkt(p, 2, 1);
        drain(200, n);
        cmp_stream("t6ord");

        // Random traffic: sparse sources, bursty sink, flickering arb_en, stray clears
        start_test();
        gap_pct = 25;
        rdy_pct = 70;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 20) begin
                int p;
                p = int'($urandom_range(NP - 1));
                if (srcq[p].size() < 10) add_pkt(p, int'($urandom_range(5, 1)), 0);
            end
            arb_en  = ($urandom_range(99) < 85);
            clr_req = ($urandom_range(99) < 3);
            step();
        end
        arb_en  = 1'b1;
        gap_pct = 0;
        rdy_pct = 100;
        drain(2000, n);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
